// File: rtl/eth_rx_decapsulation.sv
// GMII receive deframer: strips preamble/SFD, filters on destination MAC, streams payload, checks CRC-32.
// Define ETH_RX_STATS_EN to add saturating good/bad/filtered frame counters.
module eth_rx_decapsulation #(
  parameter logic [47:0] station_mac_addr = 48'h023528fbdd66,
  parameter bit          PROMISC          = 1'b0,
  parameter int unsigned min_payload_len  = 46,
  parameter int unsigned max_payload_len  = 1500
) (
  input  logic        eth_rx_clk,
  input  logic        rst,
  input  logic [7:0]  GMII_rx_d,
  input  logic        GMII_rx_dv,
  input  logic        GMII_rx_er,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        frame_good,
  output logic        frame_bad,
  output logic [15:0] len_out,
  output logic [47:0] src_mac_out,
  output logic [3:0]  dbg_state
`ifdef ETH_RX_STATS_EN
  ,
  output logic [31:0] stat_good_cnt,
  output logic [31:0] stat_bad_cnt,
  output logic [31:0] stat_filtered_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PREAMBLE = 4'd1,
    S_DEST_MAC = 4'd2,
    S_SRC_MAC  = 4'd3,
    S_LEN      = 4'd4,
    S_PAYLOAD  = 4'd5,
    S_PAD      = 4'd6,
    S_FCS      = 4'd7,
    S_STATUS   = 4'd8,
    S_WAIT_END = 4'd9
  } state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;
  logic [39:0] dest_q, dest_d;
  logic [15:0] len_q, len_d;
  logic [47:0] src_q, src_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;

  logic [31:0] crc_upd;
  logic [47:0] dest_full;
  logic [15:0] len_full;
  logic [15:0] pad_len;
  logic        dest_match;
`ifdef ETH_RX_STATS_EN
  logic        filt_inc;
`endif

  assign crc_upd    = crc32_byte(crc_q, GMII_rx_d);
  assign dest_full  = {dest_q, GMII_rx_d};
  assign len_full   = {len_q[7:0], GMII_rx_d};
  assign pad_len    = 16'(min_payload_len) - len_q;
  assign dest_match = (dest_full == station_mac_addr) || (dest_full == 48'hFFFFFFFFFFFF) || PROMISC;

  // m_valid has no ready: every beat is accepted by the downstream FIFO in the cycle it is valid.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    err_d     = err_q;
    dest_d    = dest_q;
    len_d     = len_q;
    src_d     = src_q;
    m_data_d  = m_data_q;
    m_valid_d = 1'b0;
    m_last_d  = 1'b0;
    good_d    = 1'b0;
    bad_d     = 1'b0;
`ifdef ETH_RX_STATS_EN
    filt_inc  = 1'b0;
`endif

    if ((state_q >= S_DEST_MAC) && (state_q <= S_FCS) && GMII_rx_dv && GMII_rx_er) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        cnt_d = 16'd0;
        if (GMII_rx_dv) begin
          if (GMII_rx_d == 8'h55) begin
            state_d = S_PREAMBLE;
            cnt_d   = 16'd1;
          end else if (GMII_rx_d == 8'hD5) begin
            state_d = S_DEST_MAC;
            crc_d   = CRC_INIT;
          end else begin
            state_d = S_WAIT_END;
          end
        end
      end
      S_PREAMBLE: begin
        if (!GMII_rx_dv) begin
          state_d = S_IDLE;
        end else if (GMII_rx_d == 8'hD5) begin
          state_d = S_DEST_MAC;
          cnt_d   = 16'd0;
          crc_d   = CRC_INIT;
        end else if ((GMII_rx_d == 8'h55) && (cnt_q < 16'd7)) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          state_d = S_WAIT_END;
        end
      end
      S_DEST_MAC: begin
        if (!GMII_rx_dv) begin
          state_d = S_IDLE;
        end else begin
          crc_d  = crc_upd;
          dest_d = dest_full[39:0];
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == 16'd5) begin
            cnt_d = 16'd0;
            if (dest_match) begin
              state_d = S_SRC_MAC;
            end else begin
              state_d = S_WAIT_END;
`ifdef ETH_RX_STATS_EN
              filt_inc = 1'b1;
`endif
            end
          end
        end
      end
      S_SRC_MAC: begin
        if (!GMII_rx_dv) begin
          state_d = S_STATUS;
          bad_d   = 1'b1;
        end else begin
          crc_d = crc_upd;
          src_d = {src_q[39:0], GMII_rx_d};
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd5) begin
            state_d = S_LEN;
            cnt_d   = 16'd0;
          end
        end
      end
      S_LEN: begin
        if (!GMII_rx_dv) begin
          state_d = S_STATUS;
          bad_d   = 1'b1;
        end else begin
          crc_d = crc_upd;
          len_d = len_full;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd1) begin
            cnt_d = 16'd0;
            if ((len_full == 16'd0) || (len_full > 16'(max_payload_len))) begin
              state_d = S_STATUS;
              bad_d   = 1'b1;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (!GMII_rx_dv) begin
          state_d = S_STATUS;
          bad_d   = 1'b1;
        end else begin
          crc_d     = crc_upd;
          m_valid_d = 1'b1;
          m_data_d  = GMII_rx_d;
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) begin
            m_last_d = 1'b1;
            cnt_d    = 16'd0;
            state_d  = (len_q < 16'(min_payload_len)) ? S_PAD : S_FCS;
          end
        end
      end
      S_PAD: begin
        if (!GMII_rx_dv) begin
          state_d = S_STATUS;
          bad_d   = 1'b1;
        end else begin
          crc_d = crc_upd;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == pad_len - 16'd1) begin
            state_d = S_FCS;
            cnt_d   = 16'd0;
          end
        end
      end
      S_FCS: begin
        if (!GMII_rx_dv) begin
          state_d = S_STATUS;
          bad_d   = 1'b1;
        end else begin
          crc_d = crc_upd;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd3) begin
            state_d = S_STATUS;
            cnt_d   = 16'd0;
            // Running the FCS through the register leaves a fixed residue on a clean frame.
            if ((crc_upd == CRC_RESIDUE) && !err_d) good_d = 1'b1;
            else                                    bad_d  = 1'b1;
          end
        end
      end
      S_STATUS: begin
        state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (!GMII_rx_dv) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge eth_rx_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      crc_q     <= CRC_INIT;
      err_q     <= 1'b0;
      dest_q    <= 40'd0;
      len_q     <= 16'd0;
      src_q     <= 48'd0;
      m_data_q  <= 8'd0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      dest_q    <= dest_d;
      len_q     <= len_d;
      src_q     <= src_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign frame_good  = good_q;
  assign frame_bad   = bad_q;
  assign len_out     = len_q;
  assign src_mac_out = src_q;
  assign dbg_state   = state_q;

`ifdef ETH_RX_STATS_EN
  logic [31:0] stat_good_q, stat_good_d;
  logic [31:0] stat_bad_q, stat_bad_d;
  logic [31:0] stat_filt_q, stat_filt_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    stat_good_d = stat_good_q;
    stat_bad_d  = stat_bad_q;
    stat_filt_d = stat_filt_q;
    if (good_d   && (stat_good_q != 32'hFFFFFFFF)) stat_good_d = stat_good_q + 32'd1;
    if (bad_d    && (stat_bad_q  != 32'hFFFFFFFF)) stat_bad_d  = stat_bad_q + 32'd1;
    if (filt_inc && (stat_filt_q != 32'hFFFFFFFF)) stat_filt_d = stat_filt_q + 32'd1;
  end

  always_ff @(posedge eth_rx_clk or negedge rst) begin
    if (!rst) begin
      stat_good_q <= 32'd0;
      stat_bad_q  <= 32'd0;
      stat_filt_q <= 32'd0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_bad_q  <= stat_bad_d;
      stat_filt_q <= stat_filt_d;
    end
  end

  assign stat_good_cnt     = stat_good_q;
  assign stat_bad_cnt      = stat_bad_q;
  assign stat_filtered_cnt = stat_filt_q;
`endif

endmodule

// File: tb/tb_eth_rx_decapsulation.sv
// Directed-frame bench for eth_rx_decapsulation: a frame-level model predicts beats and status pulses per cycle.
module tb_eth_rx_decapsulation;

  localparam logic [47:0] STATION = 48'h023528fbdd66;
  localparam logic [47:0] SRC1    = 48'h072227acdb65;
  localparam logic [47:0] SRC2    = 48'h1A2B3C4D5E6F;

  typedef logic [7:0] bq_t[$];

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_d;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        frame_good;
  logic        frame_bad;
  logic [15:0] len_out;
  logic [47:0] src_mac_out;
  logic [3:0]  dbg_state;
`ifdef ETH_RX_STATS_EN
  logic [31:0] stat_good_cnt;
  logic [31:0] stat_bad_cnt;
  logic [31:0] stat_filtered_cnt;
`endif

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  eth_rx_decapsulation dut (
    .eth_rx_clk (clk),
    .rst        (rst),
    .GMII_rx_d  (rx_d),
    .GMII_rx_dv (rx_dv),
    .GMII_rx_er (rx_er),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .frame_good (frame_good),
    .frame_bad  (frame_bad),
    .len_out    (len_out),
    .src_mac_out(src_mac_out),
    .dbg_state  (dbg_state)
`ifdef ETH_RX_STATS_EN
    ,
    .stat_good_cnt    (stat_good_cnt),
    .stat_bad_cnt     (stat_bad_cnt),
    .stat_filtered_cnt(stat_filtered_cnt)
`endif
  );

  // scoreboard: beats are {cycle, last, data}; status is {cycle, good}
  logic [40:0] exp_q[$];
  logic [32:0] exp_stat_q[$];
  int total = 0;
  int fails = 0;
  int exp_good = 0, exp_bad = 0, exp_filt = 0;
  logic checking = 1'b0;
  logic [31:0] crc_tab[256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_run(input bq_t q, input int from, input int to);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < to; i++) c = crc_tab[c[7:0] ^ q[i]] ^ (c >> 8);
    return c;
  endfunction

  function automatic bq_t build_frame(input int pre_n, input logic [47:0] dest, input logic [47:0] src,
                                      input logic [15:0] len, input int pay_n, input logic [7:0] pay0,
                                      input bit fcs_flip);
    bq_t f;
    int h;
    logic [31:0] c;
    for (int i = 0; i < pre_n; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    h = f.size();
    for (int i = 5; i >= 0; i--) f.push_back(dest[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) f.push_back(src[i*8 +: 8]);
    f.push_back(len[15:8]);
    f.push_back(len[7:0]);
    for (int i = 0; i < pay_n; i++) f.push_back(8'(int'(pay0) + i));
    for (int i = pay_n; i < 46; i++) f.push_back(8'h00);
    c = ~crc_run(f, h, f.size());
    for (int i = 0; i < 4; i++) f.push_back(c[i*8 +: 8]);
    if (fcs_flip) f[f.size()-4] = f[f.size()-4] ^ 8'h01;
    return f;
  endfunction

  task automatic push_status(input int c, input bit good);
    exp_stat_q.push_back({32'(c), good});
    if (good) exp_good++;
    else      exp_bad++;
  endtask

  // Frame-level model: byte i of the frame is driven in cycle base+i, outputs appear one cycle later.
  task automatic predict(input bq_t fr, input int er_pos, input int dv_len, input int base);
    int p, h, ps, len, pad, fs, n;
    logic [47:0] dest;
    logic [31:0] c;
    bit ok;
    p = 0;
    while (p < fr.size() && fr[p] == 8'h55) p++;
    if (p > 7 || p >= dv_len || fr[p] != 8'hD5) return;
    h = p + 1;
    if (dv_len < h + 6) return;
    dest = 48'd0;
    for (int i = 0; i < 6; i++) dest = (dest << 8) | 48'(fr[h+i]);
    if (!(dest == STATION || dest == 48'hFFFFFFFFFFFF)) begin
      exp_filt++;
      return;
    end
    if (dv_len < h + 14) begin
      push_status(base + dv_len + 1, 1'b0);
      return;
    end
    len = {fr[h+12], fr[h+13]};
    if (len == 0 || len > 1500) begin
      push_status(base + h + 14, 1'b0);
      return;
    end
    ps = h + 14;
    n = (dv_len - ps < len) ? dv_len - ps : len;
    for (int i = 0; i < n; i++) exp_q.push_back({32'(base + ps + i + 1), (i == len - 1), fr[ps+i]});
    pad = (len < 46) ? 46 - len : 0;
    fs = ps + len + pad;
    if (dv_len < fs + 4) begin
      push_status(base + dv_len + 1, 1'b0);
      return;
    end
    c = ~crc_run(fr, h, fs);
    ok = (c == {fr[fs+3], fr[fs+2], fr[fs+1], fr[fs]}) && !(er_pos >= h && er_pos < fs + 4);
    push_status(base + fs + 4, ok);
  endtask

  // driver
  task automatic run_frame(input bq_t fr, input int er_pos, input int dv_len);
    predict(fr, er_pos, dv_len, cyc + 1);
    for (int i = 0; i < dv_len; i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1;
      rx_d  = fr[i];
      rx_er = (i == er_pos);
    end
    repeat (12) begin
      @(posedge clk); #1;
      rx_dv = 1'b0;
      rx_d  = 8'h00;
      rx_er = 1'b0;
    end
  endtask

  // compare process
  always @(negedge clk) begin : cmp
    logic [40:0] eb;
    logic [32:0] es;
    logic ev, sv;
    if (checking) begin
      ev = 1'b0;
      sv = 1'b0;
      if (exp_q.size() > 0) ev = (int'(exp_q[0][40:9]) == cyc);
      if (exp_stat_q.size() > 0) sv = (int'(exp_stat_q[0][32:1]) == cyc);
      check("m_valid", {63'd0, m_valid}, {63'd0, ev});
      if (ev) begin
        eb = exp_q.pop_front();
        check("m_data", {56'd0, m_data}, {56'd0, eb[7:0]});
        check("m_last", {63'd0, m_last}, {63'd0, eb[8]});
      end
      es = 33'd0;
      if (sv) es = exp_stat_q.pop_front();
      check("frame_good", {63'd0, frame_good}, {63'd0, sv && es[0]});
      check("frame_bad", {63'd0, frame_bad}, {63'd0, sv && !es[0]});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f1, f;
    bq_t pin;
    logic [31:0] c;

    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
    // model pins: standard CRC-32 check values
    for (int i = 0; i < 9; i++) pin.push_back(8'(8'h31 + i));
    check("model_crc_123456789", {32'd0, ~crc_run(pin, 0, 9)}, 64'hCBF43926);
    pin = {};
    pin.push_back(8'h00);
    check("model_crc_zero_byte", {32'd0, ~crc_run(pin, 0, 1)}, 64'hD202EF8D);

    rst = 1'b0; rx_dv = 1'b0; rx_d = 8'h00; rx_er = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data", {56'd0, m_data}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_good", {63'd0, frame_good}, 64'd0);
    check("rst_bad", {63'd0, frame_bad}, 64'd0);
    check("rst_len_out", {48'd0, len_out}, 64'd0);
    check("rst_src_mac", {16'd0, src_mac_out}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    f1 = build_frame(7, STATION, SRC1, 16'h0040, 64, 8'h00, 1'b0);

    // reset in the middle of a payload: outputs clear at once, no status afterwards
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1; rx_d = f1[i];
    end
    @(posedge clk); #1;
    check("midrst_pre_valid", {63'd0, m_valid}, 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    check("midrst_len_out", {48'd0, len_out}, 64'd0);
    check("midrst_src_mac", {16'd0, src_mac_out}, 64'd0);
    rx_dv = 1'b0; rx_d = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checking = 1'b1;

    run_frame(f1, -1, f1.size());
    check("f1_len_out", {48'd0, len_out}, 64'h0040);
    check("f1_src_mac", {16'd0, src_mac_out}, 64'h072227acdb65);

    f = build_frame(7, STATION, SRC1, 16'h0010, 16, 8'h40, 1'b0);
    run_frame(f, -1, f.size());
    check("f2_len_out", {48'd0, len_out}, 64'h0010);

    f = build_frame(7, STATION, SRC1, 16'h0040, 64, 8'h00, 1'b1);
    run_frame(f, -1, f.size());

    f = build_frame(7, 48'h0A0B0C0D0E0F, SRC2, 16'h0040, 64, 8'h00, 1'b0);
    run_frame(f, -1, f.size());
    check("filtered_src_kept", {16'd0, src_mac_out}, 64'h072227acdb65);

    f = build_frame(7, 48'hFFFFFFFFFFFF, SRC2, 16'h0030, 48, 8'hA0, 1'b0);
    run_frame(f, -1, f.size());
    check("bcast_src_mac", {16'd0, src_mac_out}, 64'h1A2B3C4D5E6F);

    run_frame(f1, -1, 42);       // truncated after 20 payload bytes
    run_frame(f1, 26, f1.size()); // rx_er on payload byte 5

    f = build_frame(7, STATION, SRC1, 16'h05DD, 50, 8'h10, 1'b0);
    run_frame(f, -1, f.size());
    check("f6_len_out", {48'd0, len_out}, 64'h05DD);

    // boundaries and corner cases
    f = build_frame(7, STATION, SRC1, 16'h0000, 0, 8'h00, 1'b0);
    run_frame(f, -1, f.size());
    f = build_frame(7, STATION, SRC1, 16'd46, 46, 8'h20, 1'b0);
    run_frame(f, -1, f.size());
    f = build_frame(7, STATION, SRC1, 16'd45, 45, 8'h30, 1'b0);
    run_frame(f, -1, f.size());
    f = build_frame(7, STATION, SRC2, 16'd1500, 1500, 8'h07, 1'b0);
    run_frame(f, -1, f.size());
    f = build_frame(0, STATION, SRC1, 16'd20, 20, 8'h55, 1'b0);
    run_frame(f, -1, f.size());
    f = build_frame(8, STATION, SRC1, 16'd20, 20, 8'h00, 1'b0);
    run_frame(f, -1, f.size());
    run_frame(f1, -1, 11);       // dropped inside destination address
    run_frame(f1, -1, 14);       // dropped right after the address match
    run_frame(f1, -1, f1.size() - 2);
    run_frame(f1, 9, f1.size()); // rx_er during destination address

    repeat (5) @(posedge clk);
    #1;
    check("beats_left", 64'(exp_q.size()), 64'd0);
    check("status_left", 64'(exp_stat_q.size()), 64'd0);
`ifdef ETH_RX_STATS_EN
    check("stat_good", {32'd0, stat_good_cnt}, 64'(exp_good));
    check("stat_bad", {32'd0, stat_bad_cnt}, 64'(exp_bad));
    check("stat_filtered", {32'd0, stat_filtered_cnt}, 64'(exp_filt));
`endif
    $display("test done: total=%0d bad=%0d", total, fails);
    $finish;
  end

endmodule
